// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit for the single-bus CPU datapath.
// Define CTRL_ILLEGAL_TRAP_EN to trap opcodes 11011-11111 into HALT.
module control_sequencer #(
  parameter logic [4:0] ALU_ADD  = 5'b00011,
  parameter int         LINK_REG = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  opcode,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic        illegal_op,
  output logic [4:0]  alu_op,
  output logic        PCout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_enable,
  output logic [15:0] enableR,
  output logic        enableMAR,
  output logic        enableMDR,
  output logic        enableIR,
  output logic        enableY,
  output logic        enableZ,
  output logic        enablePC,
  output logic        enableHI,
  output logic        enableLO,
  output logic        enableCON,
  output logic        enableOutPort,
  output logic        IncPC,
  output logic        RAM_write,
  output logic [2:0]  MDR_read
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [4:0] {
    C_RALU, C_IALU, C_MD, C_UN, C_LD,
    C_LDI, C_ST, C_BR, C_JR, C_JAL,
    C_IN, C_OUT, C_MFHI, C_MFLO,
    C_NOP, C_HALT, C_ILL
  } cls_t;

  state_t state;
  state_t last;
  cls_t   cls;
  logic   stop_pending;

  always_comb begin
    cls = C_NOP;
    case (opcode)
      5'b00000: cls = C_LD;
      5'b00001: cls = C_LDI;
      5'b00010: cls = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010:
        cls = C_RALU;
      5'b01011, 5'b01100, 5'b01101: cls = C_IALU;
      5'b01110, 5'b01111: cls = C_MD;
      5'b10000, 5'b10001: cls = C_UN;
      5'b10010: cls = C_BR;
      5'b10011: cls = C_JR;
      5'b10100: cls = C_JAL;
      5'b10101: cls = C_IN;
      5'b10110: cls = C_OUT;
      5'b10111: cls = C_MFHI;
      5'b11000: cls = C_MFLO;
      5'b11001: cls = C_NOP;
      5'b11010: cls = C_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      default:  cls = C_ILL;
`else
      default:  cls = C_NOP;
`endif
    endcase
  end

  // Final execute step of each instruction class
  always_comb begin
    last = S_T2;
    case (cls)
      C_RALU, C_IALU, C_LDI: last = S_T5;
      C_MD, C_BR:            last = S_T6;
      C_LD, C_ST:            last = S_T7;
      C_UN, C_JAL:           last = S_T4;
      C_JR, C_IN, C_OUT,
      C_MFHI, C_MFLO:        last = S_T3;
      default:               last = S_T2;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clr) begin
      state        <= S_RESET;
      stop_pending <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      if (run && stop) stop_pending <= 1'b1;
      case (state)
        S_RESET: state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: begin
          if (state == S_T2 && cls == C_HALT)
            state <= S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          else if (state == S_T2 && cls == C_ILL) begin
            state     <= S_HALT;
            illegal_q <= 1'b1;
          end
`endif
          else if (state == last)
            state <= (stop_pending || stop) ? S_HALT : S_T0;
          else
            state <= state_t'(state + 4'd1);
        end
      endcase
    end
  end

  always_comb begin
    run           = (state != S_RESET) && (state != S_HALT);
    alu_op        = 5'b0;
    PCout         = 1'b0;
    ZLowout       = 1'b0;
    ZHighout      = 1'b0;
    MDRout        = 1'b0;
    HIout         = 1'b0;
    LOout         = 1'b0;
    InPortout     = 1'b0;
    Cout          = 1'b0;
    BAout         = 1'b0;
    Rout          = 1'b0;
    Gra           = 1'b0;
    Grb           = 1'b0;
    Grc           = 1'b0;
    R_enable      = 1'b0;
    enableR       = 16'b0;
    enableMAR     = 1'b0;
    enableMDR     = 1'b0;
    enableIR      = 1'b0;
    enableY       = 1'b0;
    enableZ       = 1'b0;
    enablePC      = 1'b0;
    enableHI      = 1'b0;
    enableLO      = 1'b0;
    enableCON     = 1'b0;
    enableOutPort = 1'b0;
    IncPC         = 1'b0;
    RAM_write     = 1'b0;
    MDR_read      = 3'd0;
    case (state)
      S_T0: begin
        PCout = 1'b1; enableMAR = 1'b1;
        IncPC = 1'b1; enableZ = 1'b1;
      end
      S_T1: begin
        enableMDR = 1'b1; MDR_read = 3'd1;
        ZLowout = 1'b1; enablePC = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; enableIR = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_RALU, C_IALU: begin
            Grb = 1'b1; Rout = 1'b1; enableY = 1'b1;
          end
          C_MD: begin
            Gra = 1'b1; Rout = 1'b1; enableY = 1'b1;
          end
          C_UN: begin
            Grb = 1'b1; Rout = 1'b1;
            enableZ = 1'b1; alu_op = opcode;
          end
          C_LD, C_LDI, C_ST: begin
            Grb = 1'b1; BAout = 1'b1; enableY = 1'b1;
          end
          C_BR: begin
            Gra = 1'b1; Rout = 1'b1; enableCON = 1'b1;
          end
          C_JR: begin
            Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1;
          end
          C_JAL: begin
            PCout = 1'b1; enableR[LINK_REG] = 1'b1;
          end
          C_IN: begin
            InPortout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
          end
          C_OUT: begin
            Gra = 1'b1; Rout = 1'b1; enableOutPort = 1'b1;
          end
          C_MFHI: begin
            HIout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
          end
          C_MFLO: begin
            LOout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_RALU: begin
            Grc = 1'b1; Rout = 1'b1;
            enableZ = 1'b1; alu_op = opcode;
          end
          C_IALU: begin
            Cout = 1'b1; enableZ = 1'b1; alu_op = opcode;
          end
          C_MD: begin
            Grb = 1'b1; Rout = 1'b1;
            enableZ = 1'b1; alu_op = opcode;
          end
          C_UN: begin
            ZLowout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
          end
          C_LD, C_LDI, C_ST: begin
            Cout = 1'b1; enableZ = 1'b1; alu_op = ALU_ADD;
          end
          C_BR: begin
            PCout = 1'b1; enableY = 1'b1;
          end
          C_JAL: begin
            Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_RALU, C_IALU, C_LDI: begin
            ZLowout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
          end
          C_MD: begin
            ZLowout = 1'b1; enableLO = 1'b1;
          end
          C_LD, C_ST: begin
            ZLowout = 1'b1; enableMAR = 1'b1;
          end
          C_BR: begin
            Cout = 1'b1; enableZ = 1'b1; alu_op = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_MD: begin
            ZHighout = 1'b1; enableHI = 1'b1;
          end
          C_LD: begin
            enableMDR = 1'b1; MDR_read = 3'd1;
          end
          C_ST: begin
            Gra = 1'b1; Rout = 1'b1; enableMDR = 1'b1;
          end
          C_BR: begin
            ZLowout  = con_ff;
            enablePC = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin
            MDRout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
          end
          C_ST: RAM_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for the control sequencer.
// Expected strobe vectors are queued per cycle and popped on negedge.
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [4:0]  opcode;
  logic        con_ff;
  logic        stop;
  logic        run, illegal_op;
  logic [4:0]  alu_op;
  logic        PCout, ZLowout, ZHighout, MDRout, HIout, LOout;
  logic        InPortout, Cout, BAout, Rout;
  logic        Gra, Grb, Grc, R_enable;
  logic [15:0] enableR;
  logic        enableMAR, enableMDR, enableIR, enableY, enableZ;
  logic        enablePC, enableHI, enableLO, enableCON;
  logic        enableOutPort, IncPC, RAM_write;
  logic [2:0]  MDR_read;

  control_sequencer dut (
    .clk(clk), .clr(clr), .opcode(opcode), .con_ff(con_ff),
    .stop(stop), .run(run), .illegal_op(illegal_op),
    .alu_op(alu_op), .PCout(PCout), .ZLowout(ZLowout),
    .ZHighout(ZHighout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .BAout(BAout), .Rout(Rout), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .R_enable(R_enable), .enableR(enableR),
    .enableMAR(enableMAR), .enableMDR(enableMDR),
    .enableIR(enableIR), .enableY(enableY), .enableZ(enableZ),
    .enablePC(enablePC), .enableHI(enableHI),
    .enableLO(enableLO), .enableCON(enableCON),
    .enableOutPort(enableOutPort), .IncPC(IncPC),
    .RAM_write(RAM_write), .MDR_read(MDR_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [51:0] obs;
  assign obs = {run, illegal_op, alu_op, PCout, ZLowout,
                ZHighout, MDRout, HIout, LOout, InPortout,
                Cout, BAout, Rout, Gra, Grb, Grc, R_enable,
                enableR, enableMAR, enableMDR, enableIR,
                enableY, enableZ, enablePC, enableHI,
                enableLO, enableCON, enableOutPort, IncPC,
                RAM_write, MDR_read};

  localparam logic [51:0] M_RD1  = 52'd1;
  localparam logic [51:0] M_RAMW = 52'd1 << 3;
  localparam logic [51:0] M_INC  = 52'd1 << 4;
  localparam logic [51:0] M_OUTP = 52'd1 << 5;
  localparam logic [51:0] M_CON  = 52'd1 << 6;
  localparam logic [51:0] M_LO   = 52'd1 << 7;
  localparam logic [51:0] M_HI   = 52'd1 << 8;
  localparam logic [51:0] M_PC   = 52'd1 << 9;
  localparam logic [51:0] M_Z    = 52'd1 << 10;
  localparam logic [51:0] M_Y    = 52'd1 << 11;
  localparam logic [51:0] M_IR   = 52'd1 << 12;
  localparam logic [51:0] M_MDR  = 52'd1 << 13;
  localparam logic [51:0] M_MAR  = 52'd1 << 14;
  localparam logic [51:0] M_LINK = 52'd1 << 30;
  localparam logic [51:0] M_REN  = 52'd1 << 31;
  localparam logic [51:0] M_GRC  = 52'd1 << 32;
  localparam logic [51:0] M_GRB  = 52'd1 << 33;
  localparam logic [51:0] M_GRA  = 52'd1 << 34;
  localparam logic [51:0] M_RO   = 52'd1 << 35;
  localparam logic [51:0] M_BAO  = 52'd1 << 36;
  localparam logic [51:0] M_CO   = 52'd1 << 37;
  localparam logic [51:0] M_INO  = 52'd1 << 38;
  localparam logic [51:0] M_LOO  = 52'd1 << 39;
  localparam logic [51:0] M_HIO  = 52'd1 << 40;
  localparam logic [51:0] M_MDRO = 52'd1 << 41;
  localparam logic [51:0] M_ZHI  = 52'd1 << 42;
  localparam logic [51:0] M_ZLO  = 52'd1 << 43;
  localparam logic [51:0] M_PCO  = 52'd1 << 44;
  localparam logic [51:0] M_ILL  = 52'd1 << 50;
  localparam logic [51:0] R      = 52'd1 << 51;

  function automatic logic [51:0] alu(input logic [4:0] v);
    return {2'b00, v, 45'd0};
  endfunction

  typedef struct {
    logic [51:0] v;
    string       n;
    bit          ld;
    logic [4:0]  op;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic push(input string n, input logic [51:0] v);
    exp_t e;
    e.v = v; e.n = n; e.ld = 1'b0; e.op = 5'd0;
    q.push_back(e);
  endtask

  // Opcode is presented once T0 is seen, as the IR would be
  task automatic push_fetch(input string n, input logic [4:0] op);
    exp_t e;
    e.v = R | M_PCO | M_MAR | M_INC | M_Z;
    e.n = {n, ".T0"}; e.ld = 1'b1; e.op = op;
    q.push_back(e);
    push({n, ".T1"}, R | M_MDR | M_RD1 | M_ZLO | M_PC);
    push({n, ".T2"}, R | M_MDRO | M_IR);
  endtask

  task automatic test_reset();
    exp_t e;
    clr = 1'b0;
    push("rst.c0", 52'd0);
    push("rst.c1", 52'd0);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
    end
    clr = 1'b1;
  endtask

  task automatic test_add();
    exp_t e;
    push_fetch("add", 5'b00011);
    push("add.T3", R | M_GRB | M_RO | M_Y);
    push("add.T4", R | M_GRC | M_RO | M_Z | alu(5'b00011));
    push("add.T5", R | M_ZLO | M_GRA | M_REN);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
      if (e.ld) opcode = e.op;
    end
  endtask

  task automatic test_ld_st_reset();
    exp_t e;
    push_fetch("ld", 5'b00000);
    push("ld.T3", R | M_GRB | M_BAO | M_Y);
    push("ld.T4", R | M_CO | M_Z | alu(5'b00011));
    push("ld.T5", R | M_ZLO | M_MAR);
    push("ld.T6", R | M_MDR | M_RD1);
    push("ld.T7", R | M_MDRO | M_GRA | M_REN);
    push_fetch("st", 5'b00010);
    push("st.T3", R | M_GRB | M_BAO | M_Y);
    push("st.T4", R | M_CO | M_Z | alu(5'b00011));
    push("st.T5", R | M_ZLO | M_MAR);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
      if (e.ld) opcode = e.op;
    end
    clr = 1'b0;
    push("st.rst", 52'd0);
    push("st.rst2", 52'd0);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
    end
    clr = 1'b1;
  endtask

  task automatic test_br();
    exp_t e;
    logic [31:0] ir;
    ir = 32'h9110_0023;
    for (int c = 1; c >= 0; c--) begin
      con_ff = c[0];
      push_fetch("br", ir[31:27]);
      push("br.T3", R | M_GRA | M_RO | M_CON);
      push("br.T4", R | M_PCO | M_Y);
      push("br.T5", R | M_CO | M_Z | alu(5'b00011));
      push(c ? "br.T6.taken" : "br.T6.idle",
           c ? (R | M_ZLO | M_PC) : R);
      while (q.size() > 0) begin
        @(negedge clk);
        e = q.pop_front();
        total++;
        if (obs !== e.v) begin
          bad++;
          $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
        end
        if (e.ld) opcode = e.op;
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_mul_jal();
    exp_t e;
    push_fetch("mul", 5'b01110);
    push("mul.T3", R | M_GRA | M_RO | M_Y);
    push("mul.T4", R | M_GRB | M_RO | M_Z | alu(5'b01110));
    push("mul.T5", R | M_ZLO | M_LO);
    push("mul.T6", R | M_ZHI | M_HI);
    push_fetch("jal", 5'b10100);
    push("jal.T3", R | M_PCO | M_LINK);
    push("jal.T4", R | M_GRA | M_RO | M_PC);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
      if (e.ld) opcode = e.op;
    end
  endtask

  task automatic test_misc_ops();
    exp_t e;
    push_fetch("addi", 5'b01011);
    push("addi.T3", R | M_GRB | M_RO | M_Y);
    push("addi.T4", R | M_CO | M_Z | alu(5'b01011));
    push("addi.T5", R | M_ZLO | M_GRA | M_REN);
    push_fetch("neg", 5'b10000);
    push("neg.T3", R | M_GRB | M_RO | M_Z | alu(5'b10000));
    push("neg.T4", R | M_ZLO | M_GRA | M_REN);
    push_fetch("ldi", 5'b00001);
    push("ldi.T3", R | M_GRB | M_BAO | M_Y);
    push("ldi.T4", R | M_CO | M_Z | alu(5'b00011));
    push("ldi.T5", R | M_ZLO | M_GRA | M_REN);
    push_fetch("in", 5'b10101);
    push("in.T3", R | M_INO | M_GRA | M_REN);
    push_fetch("out", 5'b10110);
    push("out.T3", R | M_GRA | M_RO | M_OUTP);
    push_fetch("mfhi", 5'b10111);
    push("mfhi.T3", R | M_HIO | M_GRA | M_REN);
    push_fetch("mflo", 5'b11000);
    push("mflo.T3", R | M_LOO | M_GRA | M_REN);
    push_fetch("jr", 5'b10011);
    push("jr.T3", R | M_GRA | M_RO | M_PC);
    push_fetch("nop", 5'b11001);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
      if (e.ld) opcode = e.op;
    end
  endtask

  task automatic test_stop();
    exp_t e;
    push_fetch("sadd", 5'b00011);
    push("sadd.T3", R | M_GRB | M_RO | M_Y);
    push("sadd.T4", R | M_GRC | M_RO | M_Z | alu(5'b00011));
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
      if (e.ld) opcode = e.op;
    end
    stop = 1'b1;
    push("sadd.T5", R | M_ZLO | M_GRA | M_REN);
    for (int i = 0; i < 10; i++)
      push($sformatf("halt.c%0d", i), 52'd0);
    while (q.size() > 0) begin
      @(negedge clk);
      stop = 1'b0;
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
    end
    clr = 1'b0;
    push("stop.rst", 52'd0);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
    end
    clr = 1'b1;
  endtask

  task automatic test_trap();
    exp_t e;
    push_fetch("ill", 5'b11100);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      push($sformatf("trap.c%0d", i), M_ILL);
`else
    push_fetch("ill.next", 5'b11001);
`endif
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
      if (e.ld) opcode = e.op;
    end
    clr = 1'b0;
    push("trap.rst", 52'd0);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
    end
    clr = 1'b1;
  endtask

  task automatic test_halt_op();
    exp_t e;
    push_fetch("halt", 5'b11010);
    for (int i = 0; i < 3; i++)
      push($sformatf("hop.c%0d", i), 52'd0);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.n, obs, e.v);
      end
      if (e.ld) opcode = e.op;
    end
  endtask

  initial begin
    clr    = 1'b0;
    stop   = 1'b0;
    con_ff = 1'b0;
    opcode = 5'd0;
    test_reset();
    test_add();
    test_ld_st_reset();
    test_br();
    test_mul_jal();
    test_misc_ops();
    test_stop();
    test_trap();
    test_halt_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
